// File: rtl/router_pkt_pkg.sv
// Shared types, constants and the header packing helper for the router packet source.
package router_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        PLD,
        PAR,
        GAP
    } state_t;

    localparam int MAX_LEN   = 63;
    localparam int BUF_DEPTH = MAX_LEN + 1;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // The router expects the length in the upper six bits and the port in the lower two.
    function automatic logic [7:0] packHeader(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_tx_buf.sv
// Payload store: one byte per slot, written by the host side and read by index on the transmit side.
module router_pkt_tx_buf
    import router_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       i_wr_en,
    input  logic [5:0] i_wr_idx,
    input  logic [7:0] i_wr_data,
    input  logic [5:0] i_rd_idx,
    output logic [7:0] o_rd_data
);

    logic [7:0] r_mem [0:BUF_DEPTH-1];

    // Capture one payload byte per accepted host beat; contents need no reset since reads only follow writes.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input: buffers a whole payload, then sends header, payload and parity.
module router_pkt_tx
    import router_pkt_pkg::*;
#(
    parameter int IFG = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [7:0]  pl_data,
    input  logic        busy,
    input  logic        err,
    output logic        pkt_valid,
    output logic [7:0]  data_out,
    output logic        tx_done,
    output logic        cmd_err,
    output logic        err_seen,
    output logic [15:0] pkt_cnt
);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_addr;
    logic [5:0]  r_len;
    logic [5:0]  r_wr_idx;
    logic [5:0]  r_rd_idx;
    logic [7:0]  r_parity;
    logic [3:0]  r_gap;
    logic        r_tx_done;
    logic        r_cmd_err;
    logic        r_err_seen;
    logic [15:0] r_pkt_cnt;

    logic        w_cmd_legal;
    logic        w_cmd_accept;
    logic        w_cmd_reject;
    logic        w_pl_accept;
    logic        w_last_load;
    logic        w_pld_adv;
    logic        w_last_pld;
    logic        w_par_accept;
    logic [7:0]  w_header;
    logic [7:0]  w_rd_data;
    logic        w_pkt_valid;
    logic [7:0]  w_data_out;
    logic        w_cmd_ready;
    logic        w_pl_ready;

    assign w_cmd_legal  = (cmd_addr != ADDR_INVALID) && (cmd_len != 6'd0);
    assign w_cmd_accept = (r_state == IDLE) && cmd_valid && w_cmd_legal;
    assign w_cmd_reject = (r_state == IDLE) && cmd_valid && !w_cmd_legal;
    assign w_pl_accept  = (r_state == LOAD) && pl_valid;
    assign w_last_load  = w_pl_accept && (r_wr_idx == r_len - 6'd1);
    assign w_pld_adv    = (r_state == PLD) && !busy;
    assign w_last_pld   = w_pld_adv && (r_rd_idx == r_len - 6'd1);
    assign w_par_accept = (r_state == PAR) && !busy;
    assign w_header     = packHeader(r_len, r_addr);

    router_pkt_tx_buf u_buf (
        .clk       (clk),
        .i_wr_en   (w_pl_accept),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (pl_data),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // State register; reset returns to IDLE at once so pkt_valid falls without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and router-facing outputs; outputs come from state and indices only, never from busy.
    always_comb begin
        w_next      = r_state;
        w_pkt_valid = 1'b0;
        w_data_out  = 8'h00;
        w_cmd_ready = 1'b0;
        w_pl_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (w_cmd_accept) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_pl_ready = 1'b1;
                if (w_last_load) begin
                    w_next = HDR;
                end
            end
            HDR: begin
                w_pkt_valid = 1'b1;
                w_data_out  = w_header;
                if (!busy) begin
                    w_next = PLD;
                end
            end
            PLD: begin
                w_pkt_valid = 1'b1;
                w_data_out  = w_rd_data;
                if (w_last_pld) begin
                    w_next = PAR;
                end
            end
            PAR: begin
                w_data_out = r_parity;
                if (!busy) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                if (r_gap <= 4'd1) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: command latch, write/read indices, running parity, gap timer, status pulses and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= 2'd0;
            r_len      <= 6'd0;
            r_wr_idx   <= 6'd0;
            r_rd_idx   <= 6'd0;
            r_parity   <= 8'h00;
            r_gap      <= 4'd0;
            r_tx_done  <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_err_seen <= 1'b0;
            r_pkt_cnt  <= 16'd0;
        end else begin
            r_tx_done <= w_par_accept;
            r_cmd_err <= w_cmd_reject;
            if (w_cmd_accept) begin
                r_addr     <= cmd_addr;
                r_len      <= cmd_len;
                r_parity   <= packHeader(cmd_len, cmd_addr);
                r_wr_idx   <= 6'd0;
                r_rd_idx   <= 6'd0;
                r_err_seen <= 1'b0;
            end
            if (w_pl_accept) begin
                r_parity <= r_parity ^ pl_data;
                r_wr_idx <= r_wr_idx + 6'd1;
                if (w_last_load) begin
                    r_rd_idx <= 6'd0;
                end
            end
            if (w_pld_adv) begin
                r_rd_idx <= r_rd_idx + 6'd1;
            end
            if (w_par_accept) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
                r_gap     <= 4'(IFG);
            end
            if (r_state == GAP) begin
                r_gap <= r_gap - 4'd1;
            end
            if (((r_state == PAR) || (r_state == GAP)) && err) begin
                r_err_seen <= 1'b1;
            end
        end
    end

    assign pkt_valid = w_pkt_valid;
    assign data_out  = w_data_out;
    assign cmd_ready = w_cmd_ready;
    assign pl_ready  = w_pl_ready;
    assign tx_done   = r_tx_done;
    assign cmd_err   = r_cmd_err;
    assign err_seen  = r_err_seen;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: drives host commands and payloads, watches the router-side stream.
module tb_router_pkt_tx;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  pl_data;
    logic        busy;
    logic        err;
    logic        pkt_valid;
    logic [7:0]  data_out;
    logic        tx_done;
    logic        cmd_err;
    logic        err_seen;
    logic [15:0] pkt_cnt;

    int vecCount = 0;
    int missCount = 0;

    logic [7:0] xferQ[$];
    logic [7:0] visQ[$];
    logic [7:0] expQ[$];
    logic [7:0] plBytes[$];
    int  txPulses = 0;
    int  cmdErrPulses = 0;
    int  pvCycles = 0;
    bit  inPkt = 0;

    router_pkt_tx #(.IFG(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .busy      (busy),
        .err       (err),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done),
        .cmd_err   (cmd_err),
        .err_seen  (err_seen),
        .pkt_cnt   (pkt_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Router-side observer: records visible bytes, transferred bytes (including parity) and pulses
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                inPkt = 0;
            end else begin
                if (tx_done) txPulses++;
                if (cmd_err) cmdErrPulses++;
                if (pkt_valid) begin
                    visQ.push_back(data_out);
                    pvCycles++;
                    inPkt = 1;
                    if (!busy) xferQ.push_back(data_out);
                end else if (inPkt && !busy) begin
                    xferQ.push_back(data_out);
                    inPkt = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "Len"}, 32'(xferQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < xferQ.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), 32'(xferQ[i]), 32'(expQ[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [1:0] addr, input logic [5:0] len);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic loadPayload(input int len, input bit gappy, input string tag);
        bit early = 0;
        checkOutput({tag, "PlReady"}, 32'(pl_ready), 1);
        checkOutput({tag, "CmdReadyLow"}, 32'(cmd_ready), 0);
        for (int i = 0; i < len; i++) begin
            if (gappy) begin
                pl_valid = 1'b0;
                step();
                if (pkt_valid) early = 1;
            end
            pl_valid = 1'b1;
            pl_data  = plBytes[i];
            step();
            if (i < len - 1 && pkt_valid) early = 1;
        end
        pl_valid = 1'b0;
        checkOutput({tag, "NoEarlyValid"}, 32'(early), 0);
        checkOutput({tag, "HdrValid"}, 32'(pkt_valid), 1);
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [5:0] len, input bit gappy, input string tag);
        xferQ.delete();
        visQ.delete();
        sendCmd(addr, len);
        loadPayload(int'(len), gappy, tag);
    endtask

    task automatic waitTx(input int budget, input string tag);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (tx_done) seen = 1;
        end
        checkOutput({tag, "TxDone"}, 32'(seen), 1);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        bit idle = 0;
        for (int c = 0; c < budget && !idle; c++) begin
            step();
            if (cmd_ready) idle = 1;
        end
        checkOutput({tag, "BackToIdle"}, 32'(idle), 1);
    endtask

    initial begin
        logic [7:0] par;
        int hdrHold;
        int a3Hold;
        int pvBefore;

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
        pl_valid = 1'b0; pl_data = 8'h00; busy = 1'b0; err = 1'b0;
        step(); step();

        // Reset values while reset is held
        checkOutput("rstPktValid", 32'(pkt_valid), 0);
        checkOutput("rstDataOut", 32'(data_out), 0);
        checkOutput("rstTxDone", 32'(tx_done), 0);
        checkOutput("rstCmdErr", 32'(cmd_err), 0);
        checkOutput("rstErrSeen", 32'(err_seen), 0);
        checkOutput("rstPktCnt", 32'(pkt_cnt), 0);
        checkOutput("rstCmdReady", 32'(cmd_ready), 1);
        checkOutput("rstPlReady", 32'(pl_ready), 0);
        rst = 1'b0;
        step();

        // Basic packet with busy low
        plBytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        txPulses = 0;
        applyStimulus(2'd1, 6'd4, 1'b0, "basic");
        waitTx(50, "basic");
        waitIdle(20, "basic");
        expQ = '{8'h11, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h15};
        checkStream("basicStream");
        checkOutput("basicValidCycles", 32'(visQ.size()), 5);
        checkOutput("basicTxPulses", 32'(txPulses), 1);
        checkOutput("basicPktCnt", 32'(pkt_cnt), 1);
        checkOutput("basicErrSeen", 32'(err_seen), 0);

        // Busy stalls: three cycles on the header, two on the third payload byte
        applyStimulus(2'd1, 6'd4, 1'b0, "stall");
        begin
            logic pat [0:10];
            pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            for (int c = 0; c < 11; c++) begin
                busy = pat[c];
                step();
            end
            busy = 1'b0;
        end
        waitTx(20, "stall");
        waitIdle(20, "stall");
        hdrHold = 0;
        a3Hold = 0;
        foreach (visQ[i]) begin
            if (visQ[i] == 8'h11) hdrHold++;
            if (visQ[i] == 8'hA3) a3Hold++;
        end
        checkStream("stallStream");
        checkOutput("stallHdrHold", 32'(hdrHold), 4);
        checkOutput("stallA3Hold", 32'(a3Hold), 3);
        checkOutput("stallValidCycles", 32'(visQ.size()), 10);
        checkOutput("stallPktCnt", 32'(pkt_cnt), 2);

        // Illegal commands are rejected with a single cmd_err pulse each
        cmdErrPulses = 0;
        pvBefore = pvCycles;
        sendCmd(2'd3, 6'd5);
        checkOutput("illAddrCmdErr", 32'(cmd_err), 1);
        checkOutput("illAddrStayIdle", 32'(cmd_ready), 1);
        step();
        checkOutput("illAddrCmdErrDrop", 32'(cmd_err), 0);
        sendCmd(2'd0, 6'd0);
        checkOutput("illLenCmdErr", 32'(cmd_err), 1);
        checkOutput("illLenStayIdle", 32'(cmd_ready), 1);
        step(); step(); step();
        checkOutput("illCmdErrPulses", 32'(cmdErrPulses), 2);
        checkOutput("illNoPktValid", 32'(pvCycles - pvBefore), 0);
        checkOutput("illPktCnt", 32'(pkt_cnt), 2);

        // Maximum length with a gap before every payload byte
        plBytes.delete();
        for (int i = 0; i < 63; i++) plBytes.push_back(8'(i * 5 + 1));
        applyStimulus(2'd2, 6'd63, 1'b1, "max");
        waitTx(200, "max");
        waitIdle(20, "max");
        expQ.delete();
        expQ.push_back(8'hFE);
        par = 8'hFE;
        for (int i = 0; i < 63; i++) begin
            expQ.push_back(plBytes[i]);
            par = par ^ plBytes[i];
        end
        expQ.push_back(par);
        checkStream("maxStream");
        checkOutput("maxPktCnt", 32'(pkt_cnt), 3);

        // err two cycles after the parity byte is accepted is captured and held
        plBytes = '{8'h5A, 8'hC3};
        applyStimulus(2'd0, 6'd2, 1'b0, "err");
        waitTx(20, "err");
        step();
        err = 1'b1;
        step();
        err = 1'b0;
        checkOutput("errSeenSet", 32'(err_seen), 1);
        waitIdle(20, "err");
        step(); step();
        checkOutput("errSeenHeldIdle", 32'(err_seen), 1);
        expQ = '{8'h08, 8'h5A, 8'hC3, 8'h91};
        checkStream("errStream");
        checkOutput("errPktCnt", 32'(pkt_cnt), 4);
        xferQ.delete();
        visQ.delete();
        plBytes = '{8'h77};
        sendCmd(2'd1, 6'd1);
        checkOutput("errSeenCleared", 32'(err_seen), 0);
        loadPayload(1, 1'b0, "clr");
        waitTx(20, "clr");
        waitIdle(20, "clr");
        expQ = '{8'h05, 8'h77, 8'h72};
        checkStream("clrStream");
        checkOutput("clrPktCnt", 32'(pkt_cnt), 5);

        // Reset while the third payload byte is on the wire
        plBytes = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        applyStimulus(2'd0, 6'd4, 1'b0, "rmid");
        step(); step(); step();
        checkOutput("rmidPreValid", 32'(pkt_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rmidPktValid", 32'(pkt_valid), 0);
        checkOutput("rmidDataOut", 32'(data_out), 0);
        checkOutput("rmidPktCnt", 32'(pkt_cnt), 0);
        step(); step();
        rst = 1'b0;
        step();
        checkOutput("rmidIdle", 32'(cmd_ready), 1);
        plBytes = '{8'h10, 8'h20, 8'h40};
        applyStimulus(2'd2, 6'd3, 1'b0, "fresh");
        waitTx(20, "fresh");
        waitIdle(20, "fresh");
        expQ = '{8'h0E, 8'h10, 8'h20, 8'h40, 8'h7E};
        checkStream("freshStream");
        checkOutput("freshPktCnt", 32'(pkt_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source that drives the router's input side (pkt_valid, data_in, busy) and is used by the router's bench and by upstream host logic. A host issues a command (destination, length) and streams the payload into an internal buffer. Once the whole payload is buffered, the block transmits header, payload and parity under the router's busy flow control. It also records the router's err response for each packet.

Parameters:
IFG, 3, idle cycles in GAP after the parity byte is accepted (legal range 1..15)
MAX_LEN, 63, maximum payload bytes; fixed by the 6-bit length field

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  host command request
cmd_ready  out  1  high when in IDLE
cmd_addr  in  2  destination port 0..2
cmd_len  in  6  payload length 1..63
pl_valid  in  1  payload byte valid
pl_ready  out  1  high when in LOAD
pl_data  in  8  payload byte
busy  in  1  router busy; a byte transfers only in a cycle with busy==0
err  in  1  router parity-error flag
pkt_valid  out  1  to router pkt_valid
data_out  out  8  to router data_in
tx_done  out  1  one-cycle pulse when the parity byte is accepted
cmd_err  out  1  one-cycle pulse when a command is rejected
err_seen  out  1  sticky: router err seen for the last packet
pkt_cnt  out  16  packets completed, wraps 0xFFFF->0

Behaviour:
- Reset (async, immediate): state IDLE; pkt_valid=0, data_out=0x00, tx_done=0, cmd_err=0, err_seen=0, pkt_cnt=0, all indices and parity cleared.
- Reset mid-packet aborts the packet at once: pkt_valid drops asynchronously and the partial packet is not counted.
- Header byte is {len[5:0], addr[1:0]}.
- Parity is the XOR of the header and all payload bytes.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with addr==3 or len==0: register cmd_err for 1 cycle next cycle; stay in IDLE.
  - On a legal cmd_valid: latch addr and len; parity<=header; wr_idx<=0; clear err_seen; go to LOAD.
- LOAD:
  - pl_ready=1.
  - On each pl_valid: buf[wr_idx]<=pl_data; parity^=pl_data; wr_idx++.
  - When the byte with wr_idx==len-1 is accepted, go to HDR with rd_idx=0.
  - Gaps in pl_valid are allowed.
- HDR: pkt_valid=1, data_out=header. If busy==0, go to PLD.
- PLD:
  - pkt_valid=1, data_out=buf[rd_idx].
  - If busy==0: rd_idx++; when rd_idx==len-1 goes to PAR.
  - If busy==1: hold data_out and pkt_valid unchanged.
- PAR:
  - pkt_valid=0, data_out=parity.
  - If busy==0: pulse tx_done, pkt_cnt++, load the gap counter with IFG, go to GAP.
- GAP:
  - pkt_valid=0, data_out=0x00.
  - Decrement the gap counter; at 0 go to IDLE.
- err monitoring: err==1 in any cycle of PAR or GAP sets err_seen. The flag holds until the next legal command is accepted.
- pkt_valid and data_out depend only on registered state, indices and buffer contents. There is no combinational path from busy.
- Timing with busy held low: header to parity is exactly len+2 consecutive cycles. IDLE accept to the first header cycle is len+1 cycles when payload is streamed back-to-back.
- Transmission never starts on a partial buffer, so payload underrun on the router side is impossible.
- cmd_valid is ignored outside IDLE. pl_valid is ignored outside LOAD.

Decomposition:
- Package router_pkt_pkg holds:
  - state enum (IDLE, LOAD, HDR, PLD, PAR, GAP);
  - MAX_LEN and ADDR_INVALID=2'b11;
  - header-pack function {len, addr}.
- One sub-module, router_pkt_tx_buf: 64x8 register array with synchronous write and combinational read by index.

Test Plan:
- Basic packet, busy=0:
  - Stimulus: cmd addr=1, len=4; payload A1,A2,A3,A4.
  - Required: data_out sequence 0x11,A1,A2,A3,A4,0x15; pkt_valid high for 5 cycles, low on 0x15; tx_done pulses once; pkt_cnt=1.
- Busy stall:
  - Stimulus: busy=1 for 3 cycles during HDR and 2 cycles mid-PLD.
  - Required: header held for 4 cycles, the stalled payload byte held for 3 cycles, byte order unchanged, parity still 0x15.
- Illegal commands:
  - Stimulus: addr=3 len=5; addr=0 len=0.
  - Required: cmd_err pulses once for each; pkt_valid never rises; pkt_cnt unchanged.
- Max length with gappy payload:
  - Stimulus: addr=2, len=63, pl_valid toggling 50%.
  - Required: header 0xFE, 63 payload bytes in order, correct XOR parity, no pkt_valid until the 63rd byte is loaded.
- Error capture:
  - Stimulus: err=1 two cycles after the parity byte is accepted.
  - Required: err_seen=1 holds through IDLE; it clears on the next legal cmd accept.
- Reset mid-PLD:
  - Stimulus: assert rst after the 2nd payload byte.
  - Required: pkt_valid=0 and data_out=0x00 immediately; pkt_cnt=0; after release, a fresh packet transmits correctly.
